// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Load-use stall and operand-forwarding controller for a classic 5-stage pipeline.
// It tracks the two instructions ahead of decode (EX and MEM) in a small scoreboard.
// From that it decides:
//   - whether the decode instruction must wait one cycle behind a load, and
//   - which pipeline result, if any, should replace each of its source operands.
// Optional feature: define HAZARD_STALL_CNT_EN to add a saturating counter of stall
// cycles on the stall_count port. Without the macro the port and counter do not exist.

module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_we,
  input  logic             dec_is_load,
  input  logic             flush,
  input  logic [31:0]      ex_result,
  input  logic [31:0]      mem_result,
  output logic             stall,
  output logic             bubble,
  output logic             hazard_raw_rs1,
  output logic             hazard_raw_rs2,
  output logic [31:0]      hazard_rs1_value,
  output logic [31:0]      hazard_rs2_value
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Result of a forwarding lookup for one source operand.
  typedef struct packed {
    logic        raw;
    logic [31:0] value;
  } fwd_t;

  state_t state;
  state_t state_next;

  // EX-stage scoreboard entry: the instruction one stage ahead of decode.
  logic       ex_v;
  logic [4:0] ex_rd;
  logic       ex_we;
  logic       ex_ld;

  // MEM-stage scoreboard entry: the instruction two stages ahead of decode.
  logic       mem_v;
  logic [4:0] mem_rd;
  logic       mem_we;

  logic load_use;
  logic ex_accept;
  fwd_t fwd_rs1;
  fwd_t fwd_rs2;

  // EX results are preferred because they are younger than MEM results.
  // A load sitting in EX has no data yet, so it cannot supply a value here.
  // In that case the lookup falls through to MEM, and the load-use stall covers it.
  // Register x0 is hard-wired to zero, so it never forwards.
  function automatic fwd_t fwd_lookup(
    input logic [4:0]  src,
    input logic        e_v,
    input logic [4:0]  e_rd,
    input logic        e_we,
    input logic        e_ld,
    input logic        m_v,
    input logic [4:0]  m_rd,
    input logic        m_we,
    input logic [31:0] e_res,
    input logic [31:0] m_res
  );
    fwd_t r;
    r.raw   = 1'b0;
    r.value = 32'h0;
    if (src != 5'd0) begin
      if (e_v && e_we && !e_ld && (e_rd == src)) begin
        r.raw   = 1'b1;
        r.value = e_res;
      end else if (m_v && m_we && (m_rd == src)) begin
        r.raw   = 1'b1;
        r.value = m_res;
      end
    end
    return r;
  endfunction

  // Detect a load in EX whose destination feeds a source of the decode instruction.
  always_comb begin
    load_use = 1'b0;
    if (dec_valid && ex_v && ex_we && ex_ld && (ex_rd != 5'd0)) begin
      load_use = (ex_rd == dec_rs1) || (ex_rd == dec_rs2);
    end
  end

  // Stall FSM: one-cycle stall on a load-use hazard, with flush overriding it.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    bubble     = 1'b0;
    unique case (state)
      RUN: begin
        if (load_use && !flush) begin
          stall      = 1'b1;
          bubble     = 1'b1;
          state_next = STALL;
        end
      end
      STALL: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Decode moves into EX only when it is valid and neither held nor squashed.
  always_comb begin
    ex_accept = dec_valid && !stall && !flush;
  end

  // Advance the scoreboard: EX takes decode or a bubble, and MEM always takes EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_rd  <= 5'd0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= 5'd0;
      mem_we <= 1'b0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (ex_accept) begin
        ex_v  <= 1'b1;
        ex_rd <= dec_rd;
        ex_we <= dec_we;
        ex_ld <= dec_is_load;
      end else begin
        ex_v  <= 1'b0;
      end
    end
  end

  // Combinational operand forwarding for both decode sources (no added latency).
  always_comb begin
    fwd_rs1 = fwd_lookup(dec_rs1, ex_v, ex_rd, ex_we, ex_ld,
                         mem_v, mem_rd, mem_we, ex_result, mem_result);
    fwd_rs2 = fwd_lookup(dec_rs2, ex_v, ex_rd, ex_we, ex_ld,
                         mem_v, mem_rd, mem_we, ex_result, mem_result);
    hazard_raw_rs1   = fwd_rs1.raw;
    hazard_rs1_value = fwd_rs1.value;
    hazard_raw_rs2   = fwd_rs2.raw;
    hazard_rs2_value = fwd_rs2.value;
  end

`ifdef HAZARD_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl.
// The driver issues one decode slot per cycle and pushes the expected response,
// taken from an instruction-level model of the pipeline, into a queue.
// A separate monitor pops that queue and compares once per cycle.
// The optional HAZARD_STALL_CNT_EN build is also covered, using a narrow counter.

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        dec_is_load;
  logic        flush;
  logic [31:0] ex_result;
  logic [31:0] mem_result;
  logic        stall;
  logic        bubble;
  logic        hazard_raw_rs1;
  logic        hazard_raw_rs2;
  logic [31:0] hazard_rs1_value;
  logic [31:0] hazard_rs2_value;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid        (dec_valid),
    .dec_rs1          (dec_rs1),
    .dec_rs2          (dec_rs2),
    .dec_rd           (dec_rd),
    .dec_we           (dec_we),
    .dec_is_load      (dec_is_load),
    .flush            (flush),
    .ex_result        (ex_result),
    .mem_result       (mem_result),
    .stall            (stall),
    .bubble           (bubble),
    .hazard_raw_rs1   (hazard_raw_rs1),
    .hazard_raw_rs2   (hazard_raw_rs2),
    .hazard_rs1_value (hazard_rs1_value),
    .hazard_rs2_value (hazard_rs2_value)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction in flight ahead of decode.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } instr_t;

  // The full expected response for one decode slot.
  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        raw1;
    logic        raw2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  string  name_q[$];

  // pipe[0] is the instruction directly ahead of decode, pipe[1] the one after it.
  instr_t pipe[$];
  bit     held_last;
  int     stalls_seen;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Empty the modelled pipeline, as a reset does.
  function automatic void model_clear();
    instr_t none;
    none = '0;
    pipe.delete();
    pipe.push_back(none);
    pipe.push_back(none);
    held_last   = 1'b0;
    stalls_seen = 0;
  endfunction

  // Search from youngest to oldest for the newest producer of src.
  // A load still one stage ahead has no data yet, so it is skipped.
  function automatic void model_forward(input logic [4:0] src, input logic [31:0] exr,
                                        input logic [31:0] mer, output logic raw,
                                        output logic [31:0] val);
    raw = 1'b0;
    val = 32'h0;
    if (src == 5'd0) return;
    for (int i = 0; i < 2; i++) begin
      if (pipe[i].v && pipe[i].we && pipe[i].rd == src && !(i == 0 && pipe[i].ld)) begin
        raw = 1'b1;
        val = (i == 0) ? exr : mer;
        return;
      end
    end
  endfunction

  // Drive one decode slot at a falling edge and record what the DUT should answer.
  task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we, input logic ld,
                                input logic fl, input logic [31:0] exr,
                                input logic [31:0] mer, input string name);
    exp_t   e;
    instr_t nxt;
    logic   waits_on_load;
    @(negedge clk);
    rst_n       = 1'b1;
    dec_valid   = v;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_rd      = rd;
    dec_we      = we;
    dec_is_load = ld;
    flush       = fl;
    ex_result   = exr;
    mem_result  = mer;

    waits_on_load = v && pipe[0].v && pipe[0].we && pipe[0].ld && pipe[0].rd != 5'd0 &&
                    (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    e        = '0;
    e.stall  = waits_on_load && !held_last && !fl;
    e.bubble = e.stall;
    model_forward(rs1, exr, mer, e.raw1, e.v1);
    model_forward(rs2, exr, mer, e.raw2, e.v2);
    e.cnt    = 32'(stalls_seen);
    exp_q.push_back(e);
    name_q.push_back(name);

    nxt.v  = v && !e.stall && !fl;
    nxt.rd = rd;
    nxt.we = we;
    nxt.ld = ld;
    pipe.push_front(nxt);
    void'(pipe.pop_back());
    held_last = e.stall;
    if (e.stall && stalls_seen < CNT_MAX) stalls_seen++;
  endtask

  // Hold reset for a number of cycles while decode keeps presenting a hazard.
  task automatic apply_reset(input int cycles, input string name);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n       = 1'b0;
      dec_valid   = 1'b1;
      dec_rs1     = 5'd7;
      dec_rs2     = 5'd7;
      dec_rd      = 5'd7;
      dec_we      = 1'b1;
      dec_is_load = 1'b1;
      flush       = 1'b0;
      ex_result   = 32'hAAAA_0000;
      mem_result  = 32'h5555_0000;
      model_clear();
      e = '0;
      exp_q.push_back(e);
      name_q.push_back(name);
    end
  endtask

  // Compare every queued expectation a little after the falling edge.
  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check_output({n, ".stall"},  32'(stall),            32'(e.stall));
        check_output({n, ".bubble"}, 32'(bubble),           32'(e.bubble));
        check_output({n, ".raw1"},   32'(hazard_raw_rs1),   32'(e.raw1));
        check_output({n, ".raw2"},   32'(hazard_raw_rs2),   32'(e.raw2));
        check_output({n, ".val1"},   hazard_rs1_value,      e.v1);
        check_output({n, ".val2"},   hazard_rs2_value,      e.v2);
`ifdef HAZARD_STALL_CNT_EN
        check_output({n, ".count"},  32'(stall_count),      e.cnt);
`endif
      end
    end
  end

  // Stop a run that somehow stops making progress.
  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin : driver
    rst_n       = 1'b0;
    dec_valid   = 1'b0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    dec_we      = 1'b0;
    dec_is_load = 1'b0;
    flush       = 1'b0;
    ex_result   = '0;
    mem_result  = '0;
    model_clear();

    apply_reset(3, "reset");

    // ALU result forwarded from EX in the same cycle.
    apply_stimulus(1, 0, 0, 5, 1, 0, 0, 32'h0, 32'h0, "add_x5");
    apply_stimulus(1, 5, 0, 6, 1, 0, 0, 32'h0000_1234, 32'h0, "use_x5");

    // Load-use: one stall cycle, then forwarding from MEM.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "idle");
    apply_stimulus(1, 0, 0, 7, 1, 1, 0, 32'h0, 32'h0, "lw_x7");
    apply_stimulus(1, 1, 7, 8, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, "use_x7_stall");
    apply_stimulus(1, 1, 7, 8, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, "use_x7_fwd");

    // The same register is in both EX and MEM; EX wins.
    apply_stimulus(1, 0, 0, 3, 1, 0, 0, 32'h0, 32'h0, "x3_old");
    apply_stimulus(1, 0, 0, 3, 1, 0, 0, 32'h0, 32'h0, "x3_new");
    apply_stimulus(1, 3, 0, 4, 1, 0, 0, 32'h11, 32'h22, "x3_prio");

    // x0 never forwards or stalls.
    apply_stimulus(1, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, "lw_x0");
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, 32'h99, 32'h98, "use_x0");
    apply_stimulus(1, 0, 0, 2, 1, 0, 0, 32'h97, 32'h96, "use_x0_again");

    // flush beats stall, and the flushed writer leaves EX empty.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "idle");
    apply_stimulus(1, 0, 0, 9, 1, 1, 0, 32'h0, 32'h0, "lw_x9");
    apply_stimulus(1, 9, 0, 10, 1, 0, 1, 32'h0, 32'h0, "flush_use_x9");
    apply_stimulus(1, 10, 9, 11, 1, 0, 0, 32'h1010, 32'h0909, "after_flush");

    // A reset during a stall cycle aborts the stall.
    apply_stimulus(1, 0, 0, 7, 1, 1, 0, 32'h0, 32'h0, "lw_x7_b");
    apply_stimulus(1, 7, 0, 8, 1, 0, 0, 32'h0, 32'h0, "stall_before_reset");
    apply_reset(1, "reset_in_stall");
    apply_stimulus(1, 7, 0, 8, 1, 0, 0, 32'h1, 32'h2, "after_reset");

    // Back-to-back dependent loads stall every other cycle and saturate the counter.
    for (int i = 0; i < 2 * CNT_MAX + 8; i++) begin
      apply_stimulus(1, 1, 0, 1, 1, 1, 0, 32'(i), 32'(i + 1000), "load_chain");
    end

    // Randomized traffic on a small register window so hazards are common.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                     5'($urandom_range(0, 5)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
                     $urandom, $urandom, "random");
      if ($urandom_range(0, 99) == 0) apply_reset(1, "random_reset");
    end

    repeat (3) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
